// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : sipo_deserializer
// Purpose  : Serial-in/parallel-out word assembler with a one-entry
//            valid/ready holding register and a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_sr_next;
  logic             w_complete;
  logic             w_accept;

  // Shift direction is fixed at elaboration time.
  generate
    if (MSB_FIRST) begin : g_msb_first
      // First received bit migrates toward the top of the word.
      always_comb begin
        w_sr_next = {r_sr[WIDTH-2:0], din};
      end
    end else begin : g_lsb_first
      // First received bit migrates toward bit 0 of the word.
      always_comb begin
        w_sr_next = {din, r_sr[WIDTH-1:1]};
      end
    end
  endgenerate

  // A word completes on the strobe that delivers its last bit.
  assign w_complete = enable && (r_cnt == C_LAST);
  // The consumer only takes a word that is actually being offered.
  assign w_accept   = dout_valid && dout_ready;

  // Bit assembly: shift register, bit counter, IDLE/SHIFT tracking and busy.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
    end else if (enable) begin
      r_sr  <= w_sr_next;
      r_cnt <= w_complete ? '0 : r_cnt + CNT_W'(1);
      busy  <= !w_complete;
      case (r_state)
        ST_IDLE:  r_state <= w_complete ? ST_IDLE : ST_SHIFT;
        ST_SHIFT: r_state <= w_complete ? ST_IDLE : ST_SHIFT;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Holding register: load on completion if free or being drained, else flag overrun.
  always_ff @(posedge clk) begin
    if (clear) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (w_complete) begin
      if (!dout_valid || w_accept) begin
        dout       <= w_sr_next;
        dout_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (w_accept) begin
      dout_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_deserializer
// Purpose  : Self-checking bench for sipo_deserializer: directed scenarios
//            plus randomized traffic against a bit-list reference model,
//            shared by three configurations (8/MSB, 8/LSB, 4/LSB).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;

  logic clk = 1'b0;
  logic clear = 1'b1;
  logic enable = 1'b0;
  logic din = 1'b0;
  logic dout_ready = 1'b0;

  logic [7:0] d0_dout, d1_dout;
  logic [3:0] d2_dout;
  logic       d0_valid, d1_valid, d2_valid;
  logic       d0_busy,  d1_busy,  d2_busy;
  logic       d0_ovr,   d1_ovr,   d2_ovr;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8m (
    .clk(clk), .clear(clear), .enable(enable), .din(din),
    .dout(d0_dout), .dout_valid(d0_valid), .dout_ready(dout_ready),
    .busy(d0_busy), .overrun(d0_ovr));

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_w8l (
    .clk(clk), .clear(clear), .enable(enable), .din(din),
    .dout(d1_dout), .dout_valid(d1_valid), .dout_ready(dout_ready),
    .busy(d1_busy), .overrun(d1_ovr));

  sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_w4l (
    .clk(clk), .clear(clear), .enable(enable), .din(din),
    .dout(d2_dout), .dout_valid(d2_valid), .dout_ready(dout_ready),
    .busy(d2_busy), .overrun(d2_ovr));

  logic [31:0] dut_dout  [3];
  logic        dut_valid [3];
  logic        dut_busy  [3];
  logic        dut_ovr   [3];
  assign dut_dout[0]  = 32'(d0_dout);
  assign dut_dout[1]  = 32'(d1_dout);
  assign dut_dout[2]  = 32'(d2_dout);
  assign dut_valid[0] = d0_valid;
  assign dut_valid[1] = d1_valid;
  assign dut_valid[2] = d2_valid;
  assign dut_busy[0]  = d0_busy;
  assign dut_busy[1]  = d1_busy;
  assign dut_busy[2]  = d2_busy;
  assign dut_ovr[0]   = d0_ovr;
  assign dut_ovr[1]   = d1_ovr;
  assign dut_ovr[2]   = d2_ovr;

  // Reference model: a list of received bits per configuration; the word is
  // built arithmetically from bit positions once the list reaches WIDTH.
  int          c_w   [3] = '{8, 8, 4};
  bit          c_msb [3] = '{1'b1, 1'b0, 1'b0};
  bit          m_bits [3][32];
  int          m_n    [3];
  logic [31:0] m_dout [3];
  bit          m_valid[3];
  bit          m_ovr  [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_n[k] = 0; m_dout[k] = '0; m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (clear) begin
        m_n[k] = 0; m_dout[k] = '0; m_valid[k] = 1'b0; m_ovr[k] = 1'b0;
      end else begin
        bit          done;
        bit          take;
        logic [31:0] word;
        done = 1'b0;
        word = '0;
        take = m_valid[k] && dout_ready;
        if (enable) begin
          m_bits[k][m_n[k]] = din;
          m_n[k] = m_n[k] + 1;
          if (m_n[k] == c_w[k]) begin
            done = 1'b1;
            for (int i = 0; i < c_w[k]; i++)
              if (m_bits[k][i])
                word = word + (32'd1 << (c_msb[k] ? (c_w[k] - 1 - i) : i));
            m_n[k] = 0;
          end
        end
        if (done) begin
          if (!m_valid[k] || take) begin
            m_dout[k] = word; m_valid[k] = 1'b1;
          end else begin
            m_ovr[k] = 1'b1;
          end
        end else if (take) begin
          m_valid[k] = 1'b0;
        end
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  // One clock: drive inputs, let the edge happen, then compare all outputs.
  task automatic cyc(input logic c, input logic e, input logic d, input logic r);
    clear = c; enable = e; din = d; dout_ready = r;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dout%0d", k),  dut_dout[k],        m_dout[k]);
      check($sformatf("valid%0d", k), 32'(dut_valid[k]),  32'(m_valid[k]));
      check($sformatf("busy%0d", k),  32'(dut_busy[k]),   32'(m_n[k] != 0));
      check($sformatf("ovr%0d", k),   32'(dut_ovr[k]),    32'(m_ovr[k]));
    end
  endtask

  // Send 8 bits, bit 7 first; 'last_rdy' is the ready level on the 8th strobe.
  task automatic send8(input logic [7:0] b, input logic rdy, input logic last_rdy);
    for (int i = 7; i >= 0; i--)
      cyc(1'b0, 1'b1, b[i], (i == 0) ? last_rdy : rdy);
  endtask

  initial begin
    logic [7:0] pat;
    // 1: reset then 8'hB2 streamed with ready high
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_dout", dut_dout[0], 32'h0);
    check("rst_busy", 32'(d0_busy), 32'h0);
    send8(8'hB2, 1'b1, 1'b1);
    check("t1_word", dut_dout[0], 32'hB2);
    check("t1_valid", 32'(d0_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_pulse", 32'(d0_valid), 32'h0);

    // 2: enable toggling, din wiggles during gaps
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    pat = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      cyc(1'b0, 1'b1, pat[i], 1'b1);
      if (i != 0) begin
        cyc(1'b0, 1'b0, ~pat[i], 1'b1);
        check("t2_busy_gap", 32'(d0_busy), 32'h1);
      end
    end
    check("t2_word", dut_dout[0], 32'hB2);

    // 3: consumer stalled, second word dropped
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send8(8'hB2, 1'b0, 1'b0);
    send8(8'h5A, 1'b0, 1'b0);
    check("t3_hold", dut_dout[0], 32'hB2);
    check("t3_ovr", 32'(d0_ovr), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_drain", 32'(d0_valid), 32'h0);
    check("t3_sticky", 32'(d0_ovr), 32'h1);

    // 4: ready exactly on the completion edge of the next word
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send8(8'hB2, 1'b0, 1'b0);
    send8(8'h5A, 1'b0, 1'b1);
    check("t4_word", dut_dout[0], 32'h5A);
    check("t4_valid", 32'(d0_valid), 32'h1);
    check("t4_ovr", 32'(d0_ovr), 32'h0);

    // 5: clear mid-word discards the partial word
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check("t5_busy", 32'(d0_busy), 32'h0);
    check("t5_dout", dut_dout[0], 32'h0);
    send8(8'h5A, 1'b1, 1'b1);
    check("t5_word", dut_dout[0], 32'h5A);

    // 6: LSB-first configurations
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    send8(8'h5A, 1'b1, 1'b1);
    check("t6_lsb8", dut_dout[1], 32'h5A);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("t6_lsb4", dut_dout[2], 32'hB);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++)
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
          1'($urandom), ($urandom_range(0, 2) != 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
Serial-in/parallel-out stage directly downstream of the enable/clear D flip-flop. It consumes the flop's registered `q` bit stream one bit per enable strobe and assembles WIDTH-bit words. Each completed word goes into a one-entry holding register with a valid/ready handshake to the next consumer. Overruns are flagged sticky.

Parameters:
- WIDTH, 8, bits per assembled word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0].

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- clear  input  1  synchronous, active-high reset; overrides every other input.
- enable  input  1  bit strobe; din is sampled only on cycles where enable=1.
- din  input  1  serial data bit, driven by the upstream flop's q.
- dout  output  WIDTH  last completed word (holding register).
- dout_valid  output  1  holding register contains an unconsumed word.
- dout_ready  input  1  consumer accepts dout on a cycle where dout_valid=1 and dout_ready=1.
- busy  output  1  a partial word is in progress (bit count != 0).
- overrun  output  1  sticky; set when a completed word is dropped.

Behaviour:
- Internal state: shift register sr[WIDTH-1:0]; bit counter cnt, 0..WIDTH-1, width $clog2(WIDTH).
- Reset (clear=1 at a rising edge):
  - sr=0, cnt=0, dout=0, dout_valid=0, overrun=0, busy=0.
  - Applies mid-word; the partial word is discarded.
  - enable, din and dout_ready are ignored that cycle.
- enable=0: sr and cnt hold. The holding register still honours the handshake.
- enable=1, shift:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], din}.
  - MSB_FIRST=0: sr <= {din, sr[WIDTH-1:1]}.
  - cnt increments.
- Completion: enable=1 and cnt==WIDTH-1.
  - The completed word is the post-shift value of sr.
  - cnt wraps to 0.
  - The word is offered to the holding register in the same edge.
- FSM (derived from cnt):
  - IDLE (cnt==0): enable goes to SHIFT.
  - SHIFT: each enable advances cnt; completion returns to IDLE.
  - busy = (cnt != 0), registered.
- Holding register, evaluated per edge with C = completion this cycle and A = dout_valid & dout_ready:
  - C & (!dout_valid | A): dout <= completed word, dout_valid <= 1.
  - C & dout_valid & !A: word dropped; dout and dout_valid unchanged; overrun <= 1.
  - !C & A: dout_valid <= 0; dout keeps its value.
  - otherwise: hold.
- Latency: dout and dout_valid update on the same edge that samples the WIDTH-th bit, so they are visible one cycle after that bit is presented.
- Back-to-back words with enable held high and dout_ready=1 give one valid word every WIDTH cycles. dout_valid pulses high for one cycle.
- overrun clears only via clear.
- dout_ready while dout_valid=0 has no effect.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
1. clear for 2 cycles; WIDTH=8, MSB_FIRST=1, enable=1, dout_ready=1; din=1,0,1,1,0,0,1,0 -> dout=8'hB2, dout_valid=1 for exactly 1 cycle (edge of 8th sample), overrun=0, busy=1 during bits 1..7, then 0.
2. Same bits with enable toggling 1/0 each cycle (din changing on enable=0 cycles is ignored) -> dout=8'hB2 after 8 strobed samples (16 cycles); busy stays 1 across gaps.
3. dout_ready=0; send 8'hB2 then 8'h5A (0,1,0,1,1,0,1,0) -> dout stays 8'hB2 with dout_valid=1; overrun=1 from the 16th sample; then dout_ready=1 -> dout_valid=0 next edge, overrun still 1.
4. Hold 8'hB2 unconsumed; assert dout_ready=1 exactly on the completion edge of 8'h5A -> dout=8'h5A, dout_valid stays 1, overrun=0.
5. Feed 5 bits, assert clear 1 cycle -> next cycle all outputs 0, busy=0; next 8 bits 0,1,0,1,1,0,1,0 -> dout=8'h5A (no residue from the partial word).
6. MSB_FIRST=0; din=0,1,0,1,1,0,1,0 -> dout=8'h5A; with WIDTH=4, din=1,1,0,1 -> dout=4'hB.
